fifo_write_conn_buf: RTL
========================

FIFO_WRITE_CONN_BUF -- requirements
Module: fifo_write_conn_buf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of data words on both sides.
REQ-002 SHALL have port ap_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port ap_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port dout  input  DATA_WIDTH  producer write data (HLS ap_fifo write side).
REQ-005 SHALL have port write  input  1  producer write strobe.
REQ-006 SHALL have port full_n  output  1  high = buffer can accept a word this cycle.
REQ-007 SHALL have port din_dst  output  DATA_WIDTH  data to downstream FIFO write port.
REQ-008 SHALL have port wr_en_dst  output  1  write enable to downstream FIFO.
REQ-009 SHALL have port full_dst  input  1  downstream FIFO full flag, active-high.
REQ-010 SHALL have port occupancy  output  2  number of buffered words, 0..2.
REQ-011 SHALL have port ovf_err  output  1  sticky flag, producer wrote while full_n low.

Function
REQ-012 SHALL contain a 2-entry in-order buffer with read pointer, write pointer (1 bit each, wrap 1->0) and 2-bit count.
REQ-013 SHALL accept a word on a rising edge when write=1 and full_n=1; dout stored at write pointer.
REQ-014 SHALL drive full_n as a register, equal to (count<2) after each edge, accounting for same-cycle accept and drain.
REQ-015 SHALL drive wr_en_dst = (count>0) AND NOT full_dst, combinationally; no other combinational input-to-output path.
REQ-016 SHALL drive din_dst from the entry at read pointer whenever count>0; value undefined-but-stable (last entry) when count=0.
REQ-017 SHALL drain one word per edge where wr_en_dst=1, advancing read pointer.
REQ-018 Latency: word accepted at edge N SHALL be presentable on wr_en_dst in the cycle after edge N at earliest; no bypass of an empty buffer.
REQ-019 Simultaneous accept and drain SHALL leave count unchanged and preserve order.
REQ-020 count=2: full_n=0; a drain that edge SHALL give count=1 and full_n=1 next cycle.
REQ-021 write=1 while full_n=0 SHALL be ignored (no storage, no pointer change) and SHALL set ovf_err until reset.
REQ-022 full_dst=1 SHALL hold buffer contents indefinitely; words never dropped or reordered.
REQ-023 occupancy SHALL equal count at all times.
REQ-024 Throughput: with full_dst=0 and continuous writes, SHALL sustain one word per cycle after first accept.

Reset
REQ-025 ap_rst_n=0 SHALL immediately clear count, pointers and ovf_err, drive full_n=0, wr_en_dst=0, occupancy=0.
REQ-026 full_n SHALL rise to 1 on the first rising edge after ap_rst_n deasserts.
REQ-027 Reset mid-operation SHALL discard buffered words; no write to downstream occurs while reset asserted.
REQ-028 Buffer data registers SHALL not require reset.

Structure
REQ-029 SHALL need no shared package; depth 2 is a local constant, DATA_WIDTH the only parameter.
REQ-030 SHALL be a single module with no sub-modules; storage is an inline 2-entry register array.

Verification
REQ-031 Reset then 4 writes 0x11,0x22,0x33,0x44 back-to-back, full_dst=0 -> wr_en_dst pulses 4 consecutive cycles starting cycle after first accept, din_dst in same order, occupancy never >1.
REQ-032 full_dst=1, writes 0xA,0xB,0xC -> A,B accepted, full_n=0 after second accept, occupancy=2, C write sets ovf_err=1; release full_dst -> A then B out, C never appears.
REQ-033 occupancy=1, write 0x5 with full_dst=0 same cycle -> occupancy stays 1, next output is held word then 0x5.
REQ-034 occupancy=2, full_dst toggles 1,0,1,0 -> exactly one drain per cycle with full_dst=0, full_n=1 the cycle after each drain.
REQ-035 ap_rst_n pulsed low asynchronously mid-cycle with occupancy=2 -> outputs clear immediately, ovf_err=0, no wr_en_dst pulse, full_n=1 one edge after release.
REQ-036 Random write/full_dst streams 10k cycles, DATA_WIDTH=8 and 64 -> scoreboard shows lossless in-order delivery when ovf_err=0.

Source files
------------

// File: rtl/fifo_write_conn_buf.sv
// -----------------------------------------------------------------------------
// fifo_write_conn_buf
//
// Two-entry in-order skid buffer between an HLS ap_fifo write side (producer)
// and the write port of a downstream FIFO. Every accepted word is stored and
// only presented downstream one cycle later at the earliest, so the producer
// never sees a combinational path from the downstream full flag.
//
// Parameters
//   DATA_WIDTH  width of data words on both sides
//
// Ports
//   ap_clk      single clock, rising edge
//   ap_rst_n    asynchronous active-low reset
//   dout        producer write data
//   write       producer write strobe
//   full_n      registered "can accept a word this cycle"
//   din_dst     data to downstream FIFO (entry at read pointer)
//   wr_en_dst   downstream write enable = (count > 0) & ~full_dst
//   full_dst    downstream FIFO full flag, active-high
//   occupancy   number of buffered words, 0..2
//   ovf_err     sticky: producer wrote while full_n was low
// -----------------------------------------------------------------------------
module fifo_write_conn_buf #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic [DATA_WIDTH-1:0] dout,
   input  logic                  write,
   output logic                  full_n,
   output logic [DATA_WIDTH-1:0] din_dst,
   output logic                  wr_en_dst,
   input  logic                  full_dst,
   output logic [1:0]            occupancy,
   output logic                  ovf_err
);

   localparam logic [1:0] DEPTH = 2'd2;

   logic [DATA_WIDTH-1:0] mem [0:1];
   logic                  rd_ptr;
   logic                  wr_ptr;
   logic [1:0]            count;
   logic [1:0]            count_next;
   logic                  full_n_q;
   logic                  ovf_q;
   logic                  accept;
   logic                  drain;

   always_comb begin
      accept     = write & full_n_q;
      drain      = (count != 2'd0) & ~full_dst;
      count_next = count;
      case ({accept, drain})
         2'b10:   count_next = count + 2'd1;
         2'b01:   count_next = count - 2'd1;
         default: count_next = count;
      endcase
   end

   // full_n is registered from the post-edge count so a drain on the same
   // edge as a full condition reopens the buffer on the very next cycle.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
         count    <= '0;
         full_n_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr <= ~wr_ptr;
         end
         if (drain) begin
            rd_ptr <= ~rd_ptr;
         end
         count    <= count_next;
         full_n_q <= (count_next != DEPTH);
         if (write && !full_n_q) begin
            ovf_q <= 1'b1;
         end
      end
   end

   // Data storage carries no reset; validity is tracked by count alone.
   always_ff @(posedge ap_clk) begin
      if (accept) begin
         mem[wr_ptr] <= dout;
      end
   end

   assign full_n    = full_n_q;
   assign wr_en_dst = drain;
   assign din_dst   = mem[rd_ptr];
   assign occupancy = count;
   assign ovf_err   = ovf_q;

endmodule
